dual_issue_fetch_queue: RTL and testbench

Instruction buffer between the instruction memory and the dual-issue decode stage. Accepts up to two sequential instructions per cycle from fetch and presents the oldest two to the F/D register as slot 1 and slot 2. It absorbs cycles in which decode consumes fewer than two instructions: a single-issue cycle after a pairing hazard, or a stall. Invalid head slots present instruction word 0, which is a nop.

---
 rtl/dual_issue_fetch_queue.sv | 93 +++++++++
 tb/tb_dual_issue_fetch_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_fetch_queue.sv
// Dual-issue fetch queue: accepts 0..2 sequential instructions/cycle, presents oldest two to decode.
// Latency 1 cycle push-to-head (no bypass); push_ready needs >=2 free entries, so an offered push is all-or-nothing.
module dual_issue_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [1:0]    push_cnt,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_instr_0,
  input  logic [31:0]   push_instr_1,
  output logic          push_ready,
  input  logic [1:0]    pop_cnt,
  output logic          head_valid_0,
  output logic          head_valid_1,
  output logic [31:0]   head_instr_0,
  output logic [31:0]   head_instr_1,
  output logic [31:0]   head_pc_0,
  output logic [31:0]   head_pc_1,
  output logic [AW:0]   count
);

  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  logic [1:0]    push_eff;
  logic [1:0]    pop_eff;
  entry_t        h0;
  entry_t        h1;

  // An encoding of 3 is meaningless on either side and is treated as no request.
  assign push_n = (push_cnt == 2'd3) ? 2'd0 : push_cnt;
  assign pop_n  = (pop_cnt  == 2'd3) ? 2'd0 : pop_cnt;

  assign push_ready = (count <= CW'(DEPTH - 2));
  assign push_eff   = push_ready ? push_n : 2'd0;

  always_comb begin
    pop_eff = 2'd0;
    if (count >= CW'(2))
      pop_eff = pop_n;
    else if (count == CW'(1))
      pop_eff = (pop_n != 2'd0) ? 2'd1 : 2'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      rd    <= rd + AW'(pop_eff);
      wr    <= wr + AW'(push_eff);
      count <= count - CW'(pop_eff) + CW'(push_eff);
    end
  end

  // Storage is not reset or cleared on flush; head gating hides stale entries.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push_eff != 2'd0)
        mem[wr] <= '{pc: push_pc, instr: push_instr_0};
      if (push_eff == 2'd2)
        mem[wr + AW'(1)] <= '{pc: push_pc + 32'd4, instr: push_instr_1};
    end
  end

  assign h0 = mem[rd];
  assign h1 = mem[rd + AW'(1)];

  assign head_valid_0 = (count != '0);
  assign head_valid_1 = (count >= CW'(2));
  assign head_instr_0 = head_valid_0 ? h0.instr : 32'd0;
  assign head_pc_0    = head_valid_0 ? h0.pc    : 32'd0;
  assign head_instr_1 = head_valid_1 ? h1.instr : 32'd0;
  assign head_pc_1    = head_valid_1 ? h1.pc    : 32'd0;

endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
// Bench for dual_issue_fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_dual_issue_fetch_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  push_cnt = 2'd0;
  logic [31:0] push_pc = '0;
  logic [31:0] push_instr_0 = '0;
  logic [31:0] push_instr_1 = '0;
  logic [1:0]  pop_cnt = 2'd0;
  logic        push_ready, head_valid_0, head_valid_1;
  logic [31:0] head_instr_0, head_instr_1, head_pc_0, head_pc_1;
  logic [AW:0] count;

  int checks = 0;
  int errors = 0;

  // Reference: program-order list of {pc, instr} currently held.
  logic [63:0] q[$];

  always #5 clk = ~clk;

  dual_issue_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push_cnt(push_cnt), .push_pc(push_pc),
    .push_instr_0(push_instr_0), .push_instr_1(push_instr_1),
    .push_ready(push_ready), .pop_cnt(pop_cnt),
    .head_valid_0(head_valid_0), .head_valid_1(head_valid_1),
    .head_instr_0(head_instr_0), .head_instr_1(head_instr_1),
    .head_pc_0(head_pc_0), .head_pc_1(head_pc_1), .count(count)
  );

  function automatic logic [31:0] e_pc(int i);
    return (q.size() > i) ? q[i][63:32] : 32'd0;
  endfunction

  function automatic logic [31:0] e_in(int i);
    return (q.size() > i) ? q[i][31:0] : 32'd0;
  endfunction

  // Applies one cycle of stimulus and advances the model by the rules of the queue.
  task automatic step(input logic fl, input logic [1:0] pc_n, input logic [31:0] pc,
                      input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] pop);
    int take, give;
    bit ready;
    flush = fl; push_cnt = pc_n; push_pc = pc; push_instr_0 = i0; push_instr_1 = i1; pop_cnt = pop;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      ready = (q.size() <= DEPTH - 2);
      give  = (pc_n == 2'd3 || !ready) ? 0 : int'(pc_n);
      take  = (pop == 2'd3) ? 0 : int'(pop);
      if (take > q.size()) take = q.size();
      repeat (take) void'(q.pop_front());
      if (give >= 1) q.push_back({pc, i0});
      if (give == 2) q.push_back({pc + 32'd4, i1});
    end
    #1;
    flush = 1'b0; push_cnt = 2'd0; pop_cnt = 2'd0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", push_ready); end
    checks++; if ({head_valid_0, head_valid_1} !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", {head_valid_0, head_valid_1}); end
    checks++; if ({head_instr_0, head_instr_1, head_pc_0, head_pc_1} !== 128'd0) begin errors++; $display("FAIL reset_heads: got %h expected 0", {head_instr_0, head_instr_1, head_pc_0, head_pc_1}); end
    #2 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_first_push();
    step(0, 2, 32'h40, 32'h2002_0005, 32'h2003_000C, 0);
    checks++; if ({head_valid_0, head_valid_1} !== 2'b11) begin errors++; $display("FAIL first_valid: got %b expected 11", {head_valid_0, head_valid_1}); end
    checks++; if (head_pc_0 !== 32'h40) begin errors++; $display("FAIL first_pc0: got %h expected 40", head_pc_0); end
    checks++; if (head_pc_1 !== 32'h44) begin errors++; $display("FAIL first_pc1: got %h expected 44", head_pc_1); end
    checks++; if (head_instr_0 !== 32'h2002_0005) begin errors++; $display("FAIL first_instr0: got %h expected 20020005", head_instr_0); end
    checks++; if (head_instr_1 !== 32'h2003_000C) begin errors++; $display("FAIL first_instr1: got %h expected 2003000c", head_instr_1); end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL first_count: got %0d expected 2", count); end
  endtask

  task automatic test_full();
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 2, 32'h200 + 8 * k, 32'hA0 + k, 32'hB0 + k, 0);
    checks++; if (count !== 4'd6 || push_ready !== 1'b1) begin errors++; $display("FAIL full_at6: got count=%0d ready=%b expected 6/1", count, push_ready); end
    step(0, 2, 32'h218, 32'hA3, 32'hB3, 0);
    checks++; if (count !== 4'd8 || push_ready !== 1'b0) begin errors++; $display("FAIL full_at8: got count=%0d ready=%b expected 8/0", count, push_ready); end
    step(0, 2, 32'h220, 32'hDEAD, 32'hBEEF, 0);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_drop: got count=%0d expected 8", count); end
    step(0, 0, 0, 0, 0, 1);
    checks++; if (count !== 4'd7 || push_ready !== 1'b0) begin errors++; $display("FAIL full_at7: got count=%0d ready=%b expected 7/0", count, push_ready); end
    step(0, 0, 0, 0, 0, 1);
    checks++; if (push_ready !== 1'b1 || head_pc_0 !== 32'h208) begin errors++; $display("FAIL full_recover: got ready=%b pc0=%h expected 1/208", push_ready, head_pc_0); end
  endtask

  task automatic test_wrap();
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 2, 32'h8 * k, 32'h100 + k, 32'h200 + k, 0);
    checks++; if (head_pc_0 !== 32'h0 || count !== 4'd8) begin errors++; $display("FAIL wrap_fill: got pc0=%h count=%0d expected 0/8", head_pc_0, count); end
    step(0, 0, 0, 0, 0, 2);
    for (int k = 0; k < 6; k++) begin
      step(0, 2, 32'h20 + 8 * k, 32'h300 + k, 32'h400 + k, 2);
      checks++; if (count !== 4'd6) begin errors++; $display("FAIL wrap_count: got %0d expected 6", count); end
      checks++; if (head_pc_0 !== 32'h10 + 8 * k || head_pc_1 !== head_pc_0 + 32'd4) begin errors++; $display("FAIL wrap_pc: got %h/%h expected %h/%h", head_pc_0, head_pc_1, 32'h10 + 8 * k, 32'h14 + 8 * k); end
    end
  endtask

  task automatic test_underflow();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h500, 32'h1234, 0, 0);
    step(0, 0, 0, 0, 0, 2);
    checks++; if (count !== 4'd0 || head_valid_0 !== 1'b0 || head_instr_0 !== 32'd0) begin errors++; $display("FAIL underflow: got count=%0d v0=%b i0=%h expected 0/0/0", count, head_valid_0, head_instr_0); end
  endtask

  task automatic test_flush();
    step(0, 2, 32'h600, 1, 2, 0);
    step(0, 2, 32'h608, 3, 4, 0);
    step(0, 1, 32'h610, 5, 0, 0);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre: got %0d expected 5", count); end
    step(1, 2, 32'h700, 6, 7, 1);
    checks++; if (count !== 4'd0 || {head_valid_0, head_valid_1, head_pc_0, head_pc_1, head_instr_0, head_instr_1} !== '0) begin errors++; $display("FAIL flush_clear: got count=%0d pc0=%h i0=%h", count, head_pc_0, head_instr_0); end
    step(0, 2, 32'h100, 32'hC0DE, 32'hF00D, 0);
    checks++; if (head_pc_0 !== 32'h100 || head_instr_1 !== 32'hF00D) begin errors++; $display("FAIL flush_after: got pc0=%h i1=%h expected 100/f00d", head_pc_0, head_instr_1); end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 0, 0, 0);
    step(0, 2, 32'h800, 8, 9, 0);
    step(0, 2, 32'h808, 10, 11, 0);
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL areset_pre: got %0d expected 4", count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (head_valid_0 !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL areset_now: got v0=%b count=%0d expected 0/0", head_valid_0, count); end
    q.delete();
    #2 reset = 1'b1;
    step(0, 2, 32'h900, 12, 13, 0);
    checks++; if (head_pc_0 !== 32'h900 || count !== 4'd2) begin errors++; $display("FAIL areset_first: got pc0=%h count=%0d expected 900/2", head_pc_0, count); end
  endtask

  task automatic test_random();
    logic [31:0] pc = 32'h1000;
    logic [1:0] pn, pp;
    bit fl;
    step(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      pn = 2'($urandom_range(0, 3));
      pp = ((n / 40) % 2 == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      fl = ($urandom_range(0, 49) == 0);
      step(fl, pn, pc, $urandom, $urandom, pp);
      pc = pc + 32'd8;
      checks++; if (count !== (AW+1)'(q.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, count, q.size()); end
      checks++; if (push_ready !== (q.size() <= DEPTH - 2)) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, push_ready, q.size() <= DEPTH - 2); end
      checks++; if (head_valid_0 !== (q.size() >= 1) || head_valid_1 !== (q.size() >= 2)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b%b size %0d", n, head_valid_0, head_valid_1, q.size()); end
      checks++; if (head_pc_0 !== e_pc(0) || head_instr_0 !== e_in(0)) begin errors++; $display("FAIL rnd_slot0[%0d]: got %h/%h expected %h/%h", n, head_pc_0, head_instr_0, e_pc(0), e_in(0)); end
      checks++; if (head_pc_1 !== e_pc(1) || head_instr_1 !== e_in(1)) begin errors++; $display("FAIL rnd_slot1[%0d]: got %h/%h expected %h/%h", n, head_pc_1, head_instr_1, e_pc(1), e_in(1)); end
    end
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_full();
    test_wrap();
    test_underflow();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
